// File: rtl/counter_bank.sv
// Bank of NCH independent up/down counters with step, limit, wrap/saturate/one-shot modes.
// Latency: one cycle from inputs to o_dat/o_tc/o_done; aggregate flags add no extra cycle.
// Backpressure: none; a count applies only when i_en & i_count, otherwise the channel holds.
module counter_bank #(
  parameter int NCH  = 4,
  parameter int DATW = 32,
  parameter int STPW = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NCH*DATW-1:0]  i_init,
  input  logic [NCH*DATW-1:0]  i_limit,
  input  logic [NCH*STPW-1:0]  i_step,
  input  logic [NCH*2-1:0]     i_mode,
  input  logic [NCH-1:0]       i_rst,
  input  logic [NCH-1:0]       i_en,
  input  logic [NCH-1:0]       i_count,
  input  logic [NCH-1:0]       i_updown,
  output logic [NCH*DATW-1:0]  o_dat,
  output logic [NCH-1:0]       o_tc,
  output logic [NCH-1:0]       o_done,
  output logic                 o_any_tc,
  output logic                 o_all_done
);

  localparam logic [1:0] MODE_SAT = 2'b01;
  localparam logic [1:0] MODE_ONE = 2'b10;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [DATW-1:0] init;
    logic [DATW-1:0] lim;
    logic [STPW-1:0] step;
    logic [1:0]      mode;
    logic [DATW-1:0] cnt_q, cnt_d;
    logic            tc_q, tc_d;
    logic            done_q, done_d;
    // Arithmetic is carried one bit wider so that limit+1 and cnt+step never overflow.
    logic [DATW:0]   cur_x, lim_x, stp_x, l1_x, sum_x;
    logic            pin_mode;

    assign init     = i_init[k*DATW +: DATW];
    assign lim      = i_limit[k*DATW +: DATW];
    assign step     = i_step[k*STPW +: STPW];
    assign mode     = i_mode[k*2 +: 2];
    assign cur_x    = {1'b0, cnt_q};
    assign lim_x    = {1'b0, lim};
    assign stp_x    = {{(DATW+1-STPW){1'b0}}, step};
    assign l1_x     = lim_x + 1'b1;
    assign sum_x    = cur_x + stp_x;
    // Saturate and one-shot both pin at the bound; wrap and the reserved code fold around.
    assign pin_mode = (mode == MODE_SAT) || (mode == MODE_ONE);

    // Next-state: load beats count beats hold; a done channel ignores counts.
    always_comb begin
      cnt_d  = cnt_q;
      tc_d   = 1'b0;
      done_d = done_q;
      if (i_rst[k]) begin
        cnt_d  = (init < lim) ? init : lim;
        done_d = 1'b0;
      end else if (i_en[k] && i_count[k] && !done_q) begin
        if (cnt_q > lim) begin
          // Limit was lowered underneath the counter: snap back into range.
          tc_d  = 1'b1;
          cnt_d = i_updown[k] ? lim : '0;
        end else if (!i_updown[k]) begin
          if (sum_x <= lim_x) begin
            cnt_d = sum_x[DATW-1:0];
          end else begin
            tc_d  = 1'b1;
            cnt_d = pin_mode ? lim : DATW'(sum_x - l1_x);
          end
        end else begin
          if (stp_x <= cur_x) begin
            cnt_d = DATW'(cur_x - stp_x);
          end else begin
            tc_d  = 1'b1;
            cnt_d = pin_mode ? '0 : DATW'(cur_x + l1_x - stp_x);
          end
        end
        if (tc_d && (mode == MODE_ONE)) done_d = 1'b1;
      end
    end

    // Channel state register with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        cnt_q  <= '0;
        tc_q   <= 1'b0;
        done_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        tc_q   <= tc_d;
        done_q <= done_d;
      end
    end

    assign o_dat[k*DATW +: DATW] = cnt_q;
    assign o_tc[k]               = tc_q;
    assign o_done[k]             = done_q;
  end

  assign o_any_tc   = |o_tc;
  assign o_all_done = &o_done;

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank: vector table, hand sequences, randomized model check.
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_counter_bank;
  localparam int NCH  = 4;
  localparam int DATW = 8;
  localparam int STPW = 8;

  logic                i_clk = 1'b0;
  logic                i_rst_n;
  logic [NCH*DATW-1:0] i_init, i_limit;
  logic [NCH*STPW-1:0] i_step;
  logic [NCH*2-1:0]    i_mode;
  logic [NCH-1:0]      i_rst, i_en, i_count, i_updown;
  logic [NCH*DATW-1:0] o_dat;
  logic [NCH-1:0]      o_tc, o_done;
  logic                o_any_tc, o_all_done;

  logic [DATW-1:0] init_a [NCH];
  logic [DATW-1:0] lim_a  [NCH];
  logic [STPW-1:0] step_a [NCH];
  logic [1:0]      mode_a [NCH];

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int m_cnt  [NCH];
  int m_done [NCH];
  int m_tc   [NCH];

  typedef struct {
    bit       rst;
    bit       en;
    bit       cnt;
    bit       ud;
    bit [1:0] mode;
    int       init;
    int       lim;
    int       step;
    int       e_dat;
    bit       e_tc;
  } vec_t;

  vec_t tbl[$];

  counter_bank #(.NCH(NCH), .DATW(DATW), .STPW(STPW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_init(i_init), .i_limit(i_limit), .i_step(i_step), .i_mode(i_mode),
    .i_rst(i_rst), .i_en(i_en), .i_count(i_count), .i_updown(i_updown),
    .o_dat(o_dat), .o_tc(o_tc), .o_done(o_done),
    .o_any_tc(o_any_tc), .o_all_done(o_all_done)
  );

  always #5 i_clk = ~i_clk;

  always_comb begin
    i_init  = '0;
    i_limit = '0;
    i_step  = '0;
    i_mode  = '0;
    for (int k = 0; k < NCH; k++) begin
      i_init[k*DATW +: DATW]  = init_a[k];
      i_limit[k*DATW +: DATW] = lim_a[k];
      i_step[k*STPW +: STPW]  = step_a[k];
      i_mode[k*2 +: 2]        = mode_a[k];
    end
  end

  function automatic void check(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  task automatic clk_step();
    @(posedge i_clk);
    #1;
  endtask

  // Behavioural rule set: one cycle of channel k given current inputs.
  task automatic ref_step(int k);
    int c, l, s, n;
    bit ev, pin;
    c   = m_cnt[k];
    l   = int'(lim_a[k]);
    s   = int'(step_a[k]);
    pin = (mode_a[k] == 2'd1) || (mode_a[k] == 2'd2);
    m_tc[k] = 0;
    if (i_rst[k]) begin
      m_cnt[k]  = (int'(init_a[k]) < l) ? int'(init_a[k]) : l;
      m_done[k] = 0;
    end else if (i_en[k] && i_count[k] && m_done[k] == 0) begin
      ev = 1'b0;
      n  = c;
      if (c > l) begin
        ev = 1'b1;
        n  = i_updown[k] ? l : 0;
      end else if (!i_updown[k]) begin
        if (c + s <= l) n = c + s;
        else begin ev = 1'b1; n = pin ? l : c + s - (l + 1); end
      end else begin
        if (s <= c) n = c - s;
        else begin ev = 1'b1; n = pin ? 0 : c + (l + 1) - s; end
      end
      m_cnt[k] = n;
      m_tc[k]  = ev ? 1 : 0;
      if (ev && mode_a[k] == 2'd2) m_done[k] = 1;
    end
  endtask

  initial begin
    int anytc, alld, l;
    i_rst_n = 1'b0;
    i_rst = '0; i_en = '0; i_count = '0; i_updown = '0;
    for (int k = 0; k < NCH; k++) begin
      init_a[k] = '0; lim_a[k] = '0; step_a[k] = '0; mode_a[k] = '0;
    end

    // Reset state.
    #12;
    check("rst_dat", int'(o_dat), 0);
    check("rst_tc", int'(o_tc), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_all_done", int'(o_all_done), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // rst en cnt ud mode init lim step -> dat tc  (channel 0)
    tbl.push_back('{1,0,0,0,2'd0,  5,  9,0,  5,0});
    tbl.push_back('{1,0,0,0,2'd0, 20,  9,0,  9,0});
    tbl.push_back('{1,0,0,0,2'd0,  0,  9,3,  0,0});
    tbl.push_back('{0,1,1,0,2'd0,  0,  9,3,  3,0});
    tbl.push_back('{0,1,1,0,2'd0,  0,  9,3,  6,0});
    tbl.push_back('{0,1,1,0,2'd0,  0,  9,3,  9,0});
    tbl.push_back('{0,1,1,0,2'd0,  0,  9,3,  2,1});
    tbl.push_back('{0,1,1,0,2'd0,  0,  9,3,  5,0});
    tbl.push_back('{0,1,1,0,2'd0,  0,  9,3,  8,0});
    tbl.push_back('{1,0,0,0,2'd0,  1,  9,3,  1,0});
    tbl.push_back('{0,1,1,1,2'd0,  0,  9,3,  8,1});
    tbl.push_back('{0,0,1,1,2'd0,  0,  9,3,  8,0});
    tbl.push_back('{1,0,0,0,2'd1,  0,  9,4,  0,0});
    tbl.push_back('{0,1,1,0,2'd1,  0,  9,4,  4,0});
    tbl.push_back('{0,1,1,0,2'd1,  0,  9,4,  8,0});
    tbl.push_back('{0,1,1,0,2'd1,  0,  9,4,  9,1});
    tbl.push_back('{0,1,1,0,2'd1,  0,  9,4,  9,1});
    tbl.push_back('{1,0,0,0,2'd1,  2,  9,4,  2,0});
    tbl.push_back('{0,1,1,1,2'd1,  0,  9,4,  0,1});
    tbl.push_back('{1,1,1,0,2'd0,  3,  9,1,  3,0});
    tbl.push_back('{0,1,1,0,2'd0,  0,  9,0,  3,0});
    tbl.push_back('{1,0,0,0,2'd0,  7,  9,1,  7,0});
    tbl.push_back('{0,0,0,0,2'd0,  0,  3,1,  7,0});
    tbl.push_back('{0,1,1,0,2'd0,  0,  3,1,  0,1});
    tbl.push_back('{1,0,0,0,2'd1,  7,  9,1,  7,0});
    tbl.push_back('{0,1,1,1,2'd1,  0,  3,1,  3,1});
    tbl.push_back('{1,0,0,0,2'd0,  0,  0,1,  0,0});
    tbl.push_back('{0,1,1,0,2'd0,  0,  0,1,  0,1});
    tbl.push_back('{0,1,1,0,2'd1,  0,  0,1,  0,1});
    tbl.push_back('{1,0,0,0,2'd0,255,255,1,255,0});
    tbl.push_back('{0,1,1,0,2'd0,  0,255,1,  0,1});
    tbl.push_back('{0,1,1,1,2'd0,  0,255,1,255,1});
    tbl.push_back('{0,1,1,1,2'd3,  0,255,1,254,0});

    foreach (tbl[i]) begin
      i_rst[0] = tbl[i].rst; i_en[0] = tbl[i].en;
      i_count[0] = tbl[i].cnt; i_updown[0] = tbl[i].ud;
      mode_a[0] = tbl[i].mode; init_a[0] = DATW'(tbl[i].init);
      lim_a[0] = DATW'(tbl[i].lim); step_a[0] = STPW'(tbl[i].step);
      clk_step();
      check($sformatf("vec%0d_dat", i), int'(o_dat[DATW-1:0]), tbl[i].e_dat);
      check($sformatf("vec%0d_tc", i), int'(o_tc[0]), int'(tbl[i].e_tc));
      check($sformatf("vec%0d_any_tc", i), int'(o_any_tc), int'(tbl[i].e_tc));
      check($sformatf("vec%0d_done", i), int'(o_done[0]), 0);
    end

    // One-shot and aggregates on all channels.
    for (int k = 0; k < NCH; k++) begin
      mode_a[k] = 2'd2; lim_a[k] = 8'd2; step_a[k] = 8'd1; init_a[k] = 8'd0;
    end
    i_updown = '0; i_en = '0; i_count = '0; i_rst = '1;
    clk_step();
    check("os_load_dat", int'(o_dat), 0);
    i_rst = '0; i_en = '1; i_count = '1;
    clk_step();
    clk_step();
    check("os_at_lim", int'(o_dat), 32'h02020202);
    i_count = 4'b0111;
    clk_step();
    check("os_done3", int'(o_done), 4'b0111);
    check("os_tc3", int'(o_tc), 4'b0111);
    check("os_all_done0", int'(o_all_done), 0);
    check("os_dat3", int'(o_dat[3*DATW +: DATW]), 2);
    i_count = 4'b1000;
    clk_step();
    check("os_done4", int'(o_done), 4'b1111);
    check("os_all_done1", int'(o_all_done), 1);
    check("os_tc_ch3", int'(o_tc), 4'b1000);
    i_count = '1;
    clk_step();
    check("os_ignored_dat", int'(o_dat), 32'h02020202);
    check("os_ignored_tc", int'(o_tc), 0);
    check("os_ignored_any", int'(o_any_tc), 0);
    i_rst = 4'b0010;
    clk_step();
    check("os_clr_done", int'(o_done), 4'b1101);
    check("os_clr_all", int'(o_all_done), 0);
    check("os_clr_dat1", int'(o_dat[DATW +: DATW]), 0);

    // Async reset asserted mid-count takes effect without a clock edge.
    i_rst = '0;
    for (int k = 0; k < NCH; k++) mode_a[k] = 2'd0;
    clk_step();
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_dat", int'(o_dat), 0);
    check("arst_tc", int'(o_tc), 0);
    check("arst_done", int'(o_done), 0);
    i_en = '0; i_count = '0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      m_cnt[k] = 0; m_done[k] = 0; m_tc[k] = 0;
    end

    // Randomized traffic against the reference model.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge i_clk); #1;
      for (int k = 0; k < NCH; k++) begin
        if (cyc == 0 || $urandom_range(0, 15) == 0)
          lim_a[k] = ($urandom_range(0, 1) == 1) ? DATW'($urandom_range(0, 15))
                                                  : DATW'($urandom_range(0, 255));
        l = int'(lim_a[k]) + 1;
        if (l > 255) l = 255;
        step_a[k]   = STPW'($urandom_range(0, l));
        init_a[k]   = DATW'($urandom_range(0, 255));
        mode_a[k]   = 2'($urandom_range(0, 3));
        i_rst[k]    = ($urandom_range(0, 11) == 0);
        i_en[k]     = ($urandom_range(0, 3) != 0);
        i_count[k]  = ($urandom_range(0, 3) != 0);
        i_updown[k] = $urandom_range(0, 1) == 1;
      end
      for (int k = 0; k < NCH; k++) ref_step(k);
      @(posedge i_clk); #1;
      anytc = 0; alld = 1;
      for (int k = 0; k < NCH; k++) begin
        check($sformatf("rnd%0d_dat%0d", cyc, k), int'(o_dat[k*DATW +: DATW]), m_cnt[k]);
        check($sformatf("rnd%0d_tc%0d", cyc, k), int'(o_tc[k]), m_tc[k]);
        check($sformatf("rnd%0d_done%0d", cyc, k), int'(o_done[k]), m_done[k]);
        if (m_tc[k] != 0) anytc = 1;
        if (m_done[k] == 0) alld = 0;
      end
      check($sformatf("rnd%0d_any_tc", cyc), int'(o_any_tc), anytc);
      check($sformatf("rnd%0d_all_done", cyc), int'(o_all_done), alld);
      // Return to the sampling phase used when driving the next vector.
      i_en = '0; i_rst = '0;
      #1;
      for (int k = 0; k < NCH; k++) ref_step(k);
      if (cyc % 2 == 0) begin
        @(posedge i_clk); #1;
        for (int k = 0; k < NCH; k++)
          check($sformatf("rnd%0d_hold%0d", cyc, k), int'(o_dat[k*DATW +: DATW]), m_cnt[k]);
      end else begin
        @(posedge i_clk); #1;
        for (int k = 0; k < NCH; k++)
          check($sformatf("rnd%0d_idle_tc%0d", cyc, k), int'(o_tc[k]), m_tc[k]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
